ifid_pipe_reg_p: RTL and testbench



---
 rtl/ifid_pipe_reg_p_pkg.sv | 28 ++
 rtl/ifid_pipe_reg_p_pipe_reg_vec.sv | 36 +++
 rtl/ifid_pipe_reg_p.sv | 82 ++++++++
 tb/tb_ifid_pipe_reg_p.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ifid_pipe_reg_p_pkg.sv
// Shared defaults for the IF/ID pipeline register and its slice register.
package ifid_pipe_reg_p_pkg;

    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned PC_W_DEF    = 16;
    localparam int unsigned CNT_W_DEF   = 8;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;

    // Resolved action taken by the register on a given edge.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_RESET = 2'd3
    } reg_act_e;

    // Resolves the rst > flush > stall > load priority into one action.
    function automatic reg_act_e resolve_act(input logic rst,
                                             input logic flush,
                                             input logic stall);
        if (rst)        return ACT_RESET;
        else if (flush) return ACT_FLUSH;
        else if (stall) return ACT_HOLD;
        else            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/ifid_pipe_reg_p_pipe_reg_vec.sv
// WIDTH-bit pipeline slice register with synchronous reset, flush and stall.
// FLUSH_LOADS=1 makes a flush behave like a load (used for the PC trace);
// otherwise a flush writes FLUSH_VAL.
module pipe_reg_vec
    import ifid_pipe_reg_p_pkg::*;
#(
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter logic [WIDTH-1:0] FLUSH_VAL  = '0,
    parameter bit              FLUSH_LOADS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    reg_act_e act;

    always_comb begin
        act = resolve_act(rst, flush, stall);
    end

    // Register update following the resolved per-edge action.
    always_ff @(posedge clk) begin
        unique case (act)
            ACT_RESET: q <= RST_VAL;
            ACT_FLUSH: q <= FLUSH_LOADS ? d : FLUSH_VAL;
            ACT_HOLD:  q <= q;
            default:   q <= d;
        endcase
    end

endmodule

// File: rtl/ifid_pipe_reg_p.sv
// IF/ID pipeline register: instruction, PC+2 and valid latch with branch
// flush (NOP bubble), stall hold and saturating stall/flush event counters.
module ifid_pipe_reg_p
    import ifid_pipe_reg_p_pkg::*;
#(
    parameter int unsigned        INSTR_W   = INSTR_W_DEF,
    parameter int unsigned        PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter int unsigned        CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_if,
    input  logic [PC_W-1:0]    pc_add2_if,
    input  logic               valid_if,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_id,
    output logic [PC_W-1:0]    pc_add2_id,
    output logic               valid_id,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [INSTR_W-1:0] instr_d;

    // Invalid fetch slots are replaced by NOP before the register, so a stale
    // instruction word is never presented to decode.
    always_comb begin
        instr_d = valid_if ? instr_if : NOP_INSTR;
    end

    pipe_reg_vec #(
        .WIDTH      (INSTR_W),
        .RST_VAL    (NOP_INSTR),
        .FLUSH_VAL  (NOP_INSTR),
        .FLUSH_LOADS(1'b0)
    ) u_instr_reg (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .stall(stall),
        .d    (instr_d),
        .q    (instr_id)
    );

    pipe_reg_vec #(
        .WIDTH      (PC_W),
        .RST_VAL    ('0),
        .FLUSH_VAL  ('0),
        .FLUSH_LOADS(1'b1)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .stall(stall),
        .d    (pc_add2_if),
        .q    (pc_add2_id)
    );

    // Valid bit: cleared on reset and flush, held on stall, else follows fetch.
    always_ff @(posedge clk) begin
        if (rst)        valid_id <= 1'b0;
        else if (flush) valid_id <= 1'b0;
        else if (!stall) valid_id <= valid_if;
    end

    // Saturating event counters; a stall masked by a flush is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifid_pipe_reg_p.sv
// Directed self-checking bench for ifid_pipe_reg_p (default widths plus a
// CNT_W=3 instance for counter saturation).
module tb_ifid_pipe_reg_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_if;
    logic [15:0] pc_add2_if;
    logic        valid_if;
    logic        stall;
    logic        flush;

    logic [15:0] instr_id;
    logic [15:0] pc_add2_id;
    logic        valid_id;
    logic [7:0]  stall_cnt;
    logic [7:0]  flush_cnt;

    logic [15:0] s_instr_id;
    logic [15:0] s_pc_add2_id;
    logic        s_valid_id;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ifid_pipe_reg_p dut (
        .clk       (clk),
        .rst       (rst),
        .instr_if  (instr_if),
        .pc_add2_if(pc_add2_if),
        .valid_if  (valid_if),
        .stall     (stall),
        .flush     (flush),
        .instr_id  (instr_id),
        .pc_add2_id(pc_add2_id),
        .valid_id  (valid_id),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    ifid_pipe_reg_p #(
        .CNT_W(3)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .instr_if  (instr_if),
        .pc_add2_if(pc_add2_if),
        .valid_if  (valid_if),
        .stall     (stall),
        .flush     (flush),
        .instr_id  (s_instr_id),
        .pc_add2_id(s_pc_add2_id),
        .valid_id  (s_valid_id),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] pc, input logic v,
                         input logic st, input logic fl);
        instr_if   = ins;
        pc_add2_if = pc;
        valid_if   = v;
        stall      = st;
        flush      = fl;
    endtask

    task automatic check_data(input string tag, input logic [15:0] ins,
                              input logic [15:0] pc, input logic v);
        check({tag, ".instr"}, 32'(instr_id), 32'(ins));
        check({tag, ".pc"},    32'(pc_add2_id), 32'(pc));
        check({tag, ".valid"}, 32'(valid_id), 32'(v));
    endtask

    initial begin
        // 1. Reset with live-looking inputs.
        rst = 1'b1;
        drive(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_data("reset", 16'h0000, 16'h0000, 1'b0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;

        // 2. Stream with one-cycle latency.
        drive(16'h1111, 16'h0002, 1'b1, 1'b0, 1'b0);
        tick();
        check_data("stream1", 16'h1111, 16'h0002, 1'b1);
        drive(16'h2222, 16'h0004, 1'b1, 1'b0, 1'b0);
        tick();
        check_data("stream2", 16'h2222, 16'h0004, 1'b1);

        // 3. Stall three cycles with changing inputs.
        drive(16'h3333, 16'h0006, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h9999, 16'h0008, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h8888, 16'h000A, 1'b0, 1'b1, 1'b0);
        tick();
        check_data("stall", 16'h2222, 16'h0004, 1'b1);
        check("stall.stall_cnt", 32'(stall_cnt), 32'd3);
        check("stall.flush_cnt", 32'(flush_cnt), 32'd0);
        drive(16'h3333, 16'h0006, 1'b1, 1'b0, 1'b0);
        tick();
        check_data("release", 16'h3333, 16'h0006, 1'b1);
        check("release.stall_cnt", 32'(stall_cnt), 32'd3);

        // 4. Flush during stall: flush wins, only flush_cnt moves.
        drive(16'h4444, 16'h0010, 1'b1, 1'b1, 1'b1);
        tick();
        check_data("flush_stall", 16'h0000, 16'h0010, 1'b0);
        check("flush_stall.flush_cnt", 32'(flush_cnt), 32'd1);
        check("flush_stall.stall_cnt", 32'(stall_cnt), 32'd3);

        // Plain flush, then normal load resumes.
        drive(16'h5555, 16'h0012, 1'b1, 1'b0, 1'b1);
        tick();
        check_data("flush", 16'h0000, 16'h0012, 1'b0);
        check("flush.flush_cnt", 32'(flush_cnt), 32'd2);
        drive(16'h5555, 16'h0014, 1'b1, 1'b0, 1'b0);
        tick();
        check_data("after_flush", 16'h5555, 16'h0014, 1'b1);

        // 5. Invalid slot never exposes the fetched word.
        drive(16'hBEEF, 16'h0016, 1'b0, 1'b0, 1'b0);
        tick();
        check_data("invalid", 16'h0000, 16'h0016, 1'b0);
        check("invalid.stall_cnt", 32'(stall_cnt), 32'd3);

        // Reset mid-stall, then a stall holds the reset values.
        drive(16'h6666, 16'h0018, 1'b1, 1'b0, 1'b0);
        tick();
        check_data("preload", 16'h6666, 16'h0018, 1'b1);
        rst = 1'b1;
        drive(16'h7777, 16'h001A, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        check_data("rst_mid_stall", 16'h0000, 16'h0000, 1'b0);
        check("rst_mid_stall.flush_cnt", 32'(flush_cnt), 32'd0);
        drive(16'h7777, 16'h001A, 1'b1, 1'b1, 1'b0);
        tick();
        check_data("stall_after_rst", 16'h0000, 16'h0000, 1'b0);
        check("stall_after_rst.stall_cnt", 32'(stall_cnt), 32'd1);

        // 6. Saturation on the CNT_W=3 instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat.reset", 32'(s_stall_cnt), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            drive(16'h1000 + 16'(i), 16'h0020, 1'b1, 1'b1, 1'b0);
            tick();
            if (i == 6) check("sat.count6", 32'(s_stall_cnt), 32'd6);
            if (i == 7) check("sat.count7", 32'(s_stall_cnt), 32'd7);
        end
        check("sat.hold", 32'(s_stall_cnt), 32'd7);
        check("sat.wide", 32'(stall_cnt), 32'd10);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat.rst", 32'(s_stall_cnt), 32'd0);
        check("sat.rst_flush", 32'(s_flush_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
